// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port between the memory-access stage and data memory.
// The stage owns the request side; memory answers with ack and read data in the same cycle.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns execute results into data-memory transactions and writeback records.
// Latency: 1 cycle for non-memory ops and exceptions; memory ops complete the cycle after dm ack.
// Backpressure: stall is high for every cycle in BUSY, so upstream holds while a transaction is open.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [31:0]                ex_alu_out,
    input  logic [31:0]                ex_rs2,
    input  logic [2:0]                 ex_funct3,
    input  logic                       ex_is_load,
    input  logic                       ex_is_store,
    input  logic [4:0]                 ex_rd,
    input  logic                       ex_reg_write,
    input  logic                       flush,
    output logic                       stall,
    mem_access_stage_if.master         dm,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic                       wb_reg_write,
    output logic [31:0]                wb_data,
    output logic [1:0]                 wb_exc
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_MISALGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL = 2'b11;

    state_t      state, state_n;
    logic [31:0] tcnt, tcnt_n;
    logic        flush_pending, flush_pending_n;
    logic [4:0]  lat_rd, lat_rd_n;
    logic        lat_rw, lat_rw_n;
    logic [2:0]  lat_f3, lat_f3_n;
    logic [1:0]  lat_off, lat_off_n;
    logic        lat_load, lat_load_n;

    logic        req_n, we_n;
    logic [31:0] addr_n, wdata_n;
    logic [3:0]  wstrb_n;
    logic        wb_valid_n, wb_rw_n;
    logic [4:0]  wb_rd_n;
    logic [31:0] wb_data_n;
    logic [1:0]  wb_exc_n;

    logic        is_mem, illegal, misaligned, expired, squash;
    logic [31:0] lane_wdata, rd_shift, load_data;
    logic [3:0]  lane_wstrb;

    assign stall = (state == BUSY);

    always_comb begin
        is_mem     = ex_is_load | ex_is_store;
        illegal    = (ex_funct3 == 3'b011)
                   | (ex_is_load  & (ex_funct3[2:1] == 2'b11))
                   | (ex_is_store & ex_funct3[2]);
        misaligned = ((ex_funct3[1:0] == 2'b01) & ex_alu_out[0])
                   | ((ex_funct3[1:0] == 2'b10) & (ex_alu_out[1:0] != 2'b00));
        case (ex_funct3[1:0])
            2'b00: begin
                lane_wstrb = 4'b0001 << ex_alu_out[1:0];
                lane_wdata = {4{ex_rs2[7:0]}};
            end
            2'b01: begin
                lane_wstrb = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{ex_rs2[15:0]}};
            end
            default: begin
                lane_wstrb = 4'b1111;
                lane_wdata = ex_rs2;
            end
        endcase
    end

    // funct3[2] selects zero-extension for LBU/LHU
    always_comb begin
        rd_shift = dm.rdata >> {lat_off, 3'b000};
        case (lat_f3[1:0])
            2'b00:   load_data = {{24{~lat_f3[2] & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   load_data = {{16{~lat_f3[2] & rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = dm.rdata;
        endcase
    end

    always_comb begin
        state_n         = state;
        tcnt_n          = tcnt;
        flush_pending_n = flush_pending;
        lat_rd_n        = lat_rd;
        lat_rw_n        = lat_rw;
        lat_f3_n        = lat_f3;
        lat_off_n       = lat_off;
        lat_load_n      = lat_load;
        req_n           = dm.req;
        we_n            = dm.we;
        addr_n          = dm.addr;
        wdata_n         = dm.wdata;
        wstrb_n         = dm.wstrb;
        wb_valid_n      = 1'b0;
        wb_rd_n         = wb_rd;
        wb_rw_n         = wb_reg_write;
        wb_data_n       = wb_data;
        wb_exc_n        = wb_exc;
        expired         = (TIMEOUT > 0) && (tcnt == 32'(TIMEOUT));
        squash          = flush_pending | flush;

        case (state)
            IDLE: begin
                if (ex_valid && !flush) begin
                    wb_rd_n   = ex_rd;
                    wb_data_n = ex_alu_out;
                    if (!is_mem) begin
                        wb_valid_n = 1'b1;
                        wb_rw_n    = ex_reg_write;
                        wb_exc_n   = EXC_NONE;
                    end else if (illegal) begin
                        wb_valid_n = 1'b1;
                        wb_rw_n    = 1'b0;
                        wb_exc_n   = EXC_ILLEGAL;
                    end else if (misaligned) begin
                        wb_valid_n = 1'b1;
                        wb_rw_n    = 1'b0;
                        wb_exc_n   = EXC_MISALGN;
                    end else begin
                        state_n         = BUSY;
                        tcnt_n          = 32'd0;
                        flush_pending_n = 1'b0;
                        lat_rd_n        = ex_rd;
                        lat_rw_n        = ex_reg_write;
                        lat_f3_n        = ex_funct3;
                        lat_off_n       = ex_alu_out[1:0];
                        lat_load_n      = ex_is_load;
                        req_n           = 1'b1;
                        we_n            = ex_is_store;
                        addr_n          = {ex_alu_out[31:2], 2'b00};
                        wdata_n         = lane_wdata;
                        wstrb_n         = ex_is_store ? lane_wstrb : 4'b0000;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    flush_pending_n = 1'b1;
                end
                // ack beats expiry when both land in the same cycle
                if (dm.ack || expired) begin
                    state_n         = IDLE;
                    req_n           = 1'b0;
                    flush_pending_n = 1'b0;
                    wb_valid_n      = ~squash;
                    wb_rd_n         = lat_rd;
                    if (dm.ack) begin
                        wb_exc_n  = EXC_NONE;
                        wb_rw_n   = lat_load & lat_rw;
                        wb_data_n = lat_load ? load_data : 32'd0;
                    end else begin
                        wb_exc_n  = EXC_TIMEOUT;
                        wb_rw_n   = 1'b0;
                        wb_data_n = 32'd0;
                    end
                end else begin
                    tcnt_n = tcnt + 32'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tcnt          <= 32'd0;
            flush_pending <= 1'b0;
            lat_rd        <= 5'd0;
            lat_rw        <= 1'b0;
            lat_f3        <= 3'd0;
            lat_off       <= 2'd0;
            lat_load      <= 1'b0;
            dm.req        <= 1'b0;
            dm.we         <= 1'b0;
            dm.addr       <= 32'd0;
            dm.wdata      <= 32'd0;
            dm.wstrb      <= 4'd0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_reg_write  <= 1'b0;
            wb_data       <= 32'd0;
            wb_exc        <= 2'd0;
        end else begin
            state         <= state_n;
            tcnt          <= tcnt_n;
            flush_pending <= flush_pending_n;
            lat_rd        <= lat_rd_n;
            lat_rw        <= lat_rw_n;
            lat_f3        <= lat_f3_n;
            lat_off       <= lat_off_n;
            lat_load      <= lat_load_n;
            dm.req        <= req_n;
            dm.we         <= we_n;
            dm.addr       <= addr_n;
            dm.wdata      <= wdata_n;
            dm.wstrb      <= wstrb_n;
            wb_valid      <= wb_valid_n;
            wb_rd         <= wb_rd_n;
            wb_reg_write  <= wb_rw_n;
            wb_data       <= wb_data_n;
            wb_exc        <= wb_exc_n;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table through a writeback scoreboard, plus timeout,
// flush and reset sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_out = '0;
    logic [31:0] ex_rs2 = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    mem_access_stage_if dm_bus ();

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_alu_out   (ex_alu_out),
        .ex_rs2       (ex_rs2),
        .ex_funct3    (ex_funct3),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .flush        (flush),
        .stall        (stall),
        .dm           (dm_bus),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .wb_exc       (wb_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        ld;
        logic        st;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        int          dly;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic [1:0]  exp_exc;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic [1:0]  exc;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // writeback monitor: every wb_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (stall === 1'b1) stall_cnt++;
        if (!rst && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d data=0x%08h exc=%0d expected no writeback at %0t",
                         wb_rd, wb_data, wb_exc, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_exc", {30'd0, wb_exc}, {30'd0, e.exc});
                chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
                if (e.chk_data) chk("wb_data", wb_data, e.data);
                if (e.rw) chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            end
        end
    end

    task automatic drive_op(input vec_t v);
        ex_alu_out   = v.alu;
        ex_rs2       = v.rs2;
        ex_funct3    = v.f3;
        ex_is_load   = v.ld;
        ex_is_store  = v.st;
        ex_rd        = v.rd;
        ex_reg_write = v.rw;
        ex_valid     = 1'b1;
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   base;
        drive_op(v);
        e.rd = v.rd; e.rw = v.exp_rw; e.data = v.exp_data; e.exc = v.exp_exc; e.chk_data = v.chk_data;
        sb.push_back(e);
        base = stall_cnt;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("dm_req", {31'd0, dm_bus.req}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            chk("dm_addr", dm_bus.addr, v.exp_addr);
            chk("dm_we", {31'd0, dm_bus.we}, {31'd0, v.st});
            chk("dm_wstrb", {28'd0, dm_bus.wstrb}, {28'd0, v.exp_strb});
            if (v.st) chk("dm_wdata", dm_bus.wdata, v.exp_wdata);
            for (int i = 0; i < v.dly; i++) begin
                @(posedge clk); #1;
            end
            chk("dm_req_held", {31'd0, dm_bus.req}, 32'd1);
            dm_bus.ack   = 1'b1;
            dm_bus.rdata = v.rdata;
            @(posedge clk); #1;
            dm_bus.ack   = 1'b0;
            dm_bus.rdata = 32'h0;
            chk("dm_req_drop", {31'd0, dm_bus.req}, 32'd0);
            chk("stall_cycles", stall_cnt - base, v.dly + 1);
        end else begin
            chk("stall_low", {31'd0, stall}, 32'd0);
        end
    endtask

    initial begin
        int   hi;
        vec_t v;
        exp_t e;

        //        alu           rs2           f3  ld st rd  rw rdata         dly req addr       wdata         strb     data          rw exc   cd
        vt[0]  = '{32'h00001234, 32'h0,        3'd0,1'b0,1'b0,5'd5, 1'b1,32'h0,        0, 1'b0,32'h0,    32'h0,        4'b0000, 32'h00001234, 1'b1,2'd0,1'b1};
        vt[1]  = '{32'h00000103, 32'hAABBCCDD, 3'd0,1'b0,1'b1,5'd6, 1'b0,32'h0,        3, 1'b1,32'h100,  32'hDDDDDDDD, 4'b1000, 32'h0,        1'b0,2'd0,1'b1};
        vt[2]  = '{32'h00000201, 32'h0,        3'd0,1'b1,1'b0,5'd3, 1'b1,32'h0000F000, 1, 1'b1,32'h200,  32'h0,        4'b0000, 32'hFFFFFFF0, 1'b1,2'd0,1'b1};
        vt[3]  = '{32'h00000201, 32'h0,        3'd4,1'b1,1'b0,5'd4, 1'b1,32'h0000F000, 1, 1'b1,32'h200,  32'h0,        4'b0000, 32'h000000F0, 1'b1,2'd0,1'b1};
        vt[4]  = '{32'h00000202, 32'h0,        3'd1,1'b1,1'b0,5'd7, 1'b1,32'h80010000, 2, 1'b1,32'h200,  32'h0,        4'b0000, 32'hFFFF8001, 1'b1,2'd0,1'b1};
        vt[5]  = '{32'h00000202, 32'h0,        3'd5,1'b1,1'b0,5'd8, 1'b1,32'h80010000, 2, 1'b1,32'h200,  32'h0,        4'b0000, 32'h00008001, 1'b1,2'd0,1'b1};
        vt[6]  = '{32'h00000300, 32'h0,        3'd2,1'b1,1'b0,5'd9, 1'b1,32'hDEADBEEF, 0, 1'b1,32'h300,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b1,2'd0,1'b1};
        vt[7]  = '{32'h00000402, 32'h11223344, 3'd1,1'b0,1'b1,5'd1, 1'b0,32'h0,        1, 1'b1,32'h400,  32'h33443344, 4'b1100, 32'h0,        1'b0,2'd0,1'b1};
        vt[8]  = '{32'h00000500, 32'hCAFEF00D, 3'd2,1'b0,1'b1,5'd2, 1'b0,32'h0,        2, 1'b1,32'h500,  32'hCAFEF00D, 4'b1111, 32'h0,        1'b0,2'd0,1'b1};
        vt[9]  = '{32'h00000302, 32'h0,        3'd2,1'b1,1'b0,5'd9, 1'b1,32'h0,        0, 1'b0,32'h0,    32'h0,        4'b0000, 32'h0,        1'b0,2'd1,1'b0};
        vt[10] = '{32'h00000300, 32'h0,        3'd3,1'b1,1'b0,5'd9, 1'b1,32'h0,        0, 1'b0,32'h0,    32'h0,        4'b0000, 32'h0,        1'b0,2'd3,1'b0};
        vt[11] = '{32'h00000500, 32'h0,        3'd4,1'b0,1'b1,5'd0, 1'b0,32'h0,        0, 1'b0,32'h0,    32'h0,        4'b0000, 32'h0,        1'b0,2'd3,1'b0};
        vt[12] = '{32'h00000401, 32'h0,        3'd1,1'b0,1'b1,5'd0, 1'b0,32'h0,        0, 1'b0,32'h0,    32'h0,        4'b0000, 32'h0,        1'b0,2'd1,1'b0};
        vt[13] = '{32'h00000203, 32'h0,        3'd0,1'b1,1'b0,5'd10,1'b1,32'h7F000000, 1, 1'b1,32'h200,  32'h0,        4'b0000, 32'h0000007F, 1'b1,2'd0,1'b1};
        vt[14] = '{32'hFFFFFFFF, 32'h0,        3'd0,1'b0,1'b0,5'd0, 1'b0,32'h0,        0, 1'b0,32'h0,    32'h0,        4'b0000, 32'hFFFFFFFF, 1'b0,2'd0,1'b1};
        vt[15] = '{32'h00000100, 32'h000000A5, 3'd0,1'b0,1'b1,5'd0, 1'b0,32'h0,        0, 1'b1,32'h100,  32'hA5A5A5A5, 4'b0001, 32'h0,        1'b0,2'd0,1'b1};

        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dm_bus.req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_op(vt[i]);

        // timeout with no ack: request stays up five cycles, then a bus-error writeback
        v = vt[6];
        v.alu = 32'h600;
        drive_op(v);
        e.rd = 5'd9; e.rw = 1'b0; e.data = 32'h0; e.exc = 2'd2; e.chk_data = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 20 && dm_bus.req === 1'b1; i++) begin
            hi++;
            @(posedge clk); #1;
        end
        chk("timeout_req_cycles", hi, 5);
        chk("timeout_stall_low", {31'd0, stall}, 32'd0);

        // ack landing on the expiry cycle completes normally
        v = vt[6];
        v.alu = 32'h600; v.exp_addr = 32'h600; v.rdata = 32'h12345678; v.exp_data = 32'h12345678; v.dly = 4;
        run_op(v);

        // flush while a store is in flight: store finishes silently, next op accepted right after
        v = vt[8];
        v.alu = 32'h700;
        drive_op(v);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_req_held", {31'd0, dm_bus.req}, 32'd1);
        dm_bus.ack = 1'b1;
        @(posedge clk); #1;
        dm_bus.ack = 1'b0;
        chk("flush_req_drop", {31'd0, dm_bus.req}, 32'd0);
        run_op(vt[0]);

        // flush in IDLE drops the incoming op
        drive_op(vt[6]);
        flush = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        flush = 1'b0;
        chk("idle_flush_req", {31'd0, dm_bus.req}, 32'd0);

        // reset mid-transaction clears every output, and a late ack is ignored
        drive_op(vt[8]);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_req", {31'd0, dm_bus.req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_addr", dm_bus.addr, 32'd0);
        chk("mid_rst_wdata", dm_bus.wdata, 32'd0);
        chk("mid_rst_wstrb", {28'd0, dm_bus.wstrb}, 32'd0);
        chk("mid_rst_we", {31'd0, dm_bus.we}, 32'd0);
        chk("mid_rst_wb", {wb_valid, wb_reg_write, wb_exc, wb_rd, 23'd0}, 32'd0);
        dm_bus.ack = 1'b1;
        @(posedge clk); #1;
        dm_bus.ack = 1'b0;
        chk("late_ack_req", {31'd0, dm_bus.req}, 32'd0);
        run_op(vt[14]);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
